// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED counter sequencing controller.
// Imported by led_counter_ctrl and led_tick_prescaler.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;
    localparam int PW_DEF    = 8;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : led_ctrl_pkg

// File: rtl/led_tick_prescaler.sv
// Programmable step prescaler: one step every prescale+1 enabled cycles.
// The >= compare lets a lowered prescale take effect on the very next cycle.
module led_tick_prescaler
    import led_ctrl_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [PW-1:0] prescale,
    output logic          step
);

    logic [PW-1:0] pre_cnt_r;
    logic          step_s;

    // Step is offered only while counting and not being cleared in the same cycle.
    always_comb begin
        step_s = 1'b0;
        if (en && !clr) begin
            step_s = (pre_cnt_r >= prescale);
        end else begin
            step_s = 1'b0;
        end
    end

    // Prescaler count: cleared on reset/clear/step, advanced while enabled, else retained.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= {PW{1'b0}};
        end else if (clr) begin
            pre_cnt_r <= {PW{1'b0}};
        end else if (step_s) begin
            pre_cnt_r <= {PW{1'b0}};
        end else if (en) begin
            pre_cnt_r <= pre_cnt_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            pre_cnt_r <= pre_cnt_r;
        end
    end

    assign step = step_s;

endmodule : led_tick_prescaler

// File: rtl/led_counter_ctrl.sv
// Run/pause/stop sequencing controller driving the LED count register directly.
// Optional boundary-crossing pulse output enabled by defining LED_CTRL_WRAP_EN.
module led_counter_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PW    = PW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PW-1:0]    prescale,
`ifdef LED_CTRL_WRAP_EN
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             busy
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] led_r;
    logic [WIDTH-1:0] led_nxt_s;
    logic             tick_r;
    logic             tick_nxt_s;
    logic             busy_r;
    logic             pre_en_s;
    logic             pre_clr_s;
    logic             step_s;

    led_tick_prescaler #(
        .PW(PW)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (pre_en_s),
        .clr     (pre_clr_s),
        .prescale(prescale),
        .step    (step_s)
    );

    // Next-state decode; stop always beats start, and load forces a prescaler clear.
    always_comb begin
        state_nxt_s = state_r;
        pre_en_s    = 1'b0;
        pre_clr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                pre_clr_s = 1'b1;
                if (start && !stop) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = RUN;
                    pre_en_s    = 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_nxt_s = IDLE;
                    pre_clr_s   = 1'b1;
                end else if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pre_clr_s   = 1'b1;
            end
        endcase
        pre_clr_s = pre_clr_s | load;
    end

    // Count update: load overrides a coincident step and suppresses its tick.
    always_comb begin
        led_nxt_s  = led_r;
        tick_nxt_s = 1'b0;
        if (load) begin
            led_nxt_s = load_val;
        end else if (step_s) begin
            tick_nxt_s = 1'b1;
            if (dir == DIR_DOWN) begin
                led_nxt_s = led_r - {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                led_nxt_s = led_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            led_nxt_s = led_r;
        end
    end

    // State, count and status registers; rst outranks every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            led_r   <= {WIDTH{1'b0}};
            tick_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            led_r   <= led_nxt_s;
            tick_r  <= tick_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

`ifdef LED_CTRL_WRAP_EN
    logic wrap_nxt_s;
    logic wrap_r;

    // Boundary crossing: 0xF->0x0 counting up or 0x0->0xF counting down.
    always_comb begin
        wrap_nxt_s = 1'b0;
        if (step_s && !load) begin
            if (dir == DIR_DOWN) begin
                wrap_nxt_s = (led_r == {WIDTH{1'b0}});
            end else begin
                wrap_nxt_s = (led_r == {WIDTH{1'b1}});
            end
        end else begin
            wrap_nxt_s = 1'b0;
        end
    end

    // Wrap pulse register, aligned with tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_nxt_s;
        end
    end

    assign wrap = wrap_r;
`endif

    assign led  = led_r;
    assign tick = tick_r;
    assign busy = busy_r;

endmodule : led_counter_ctrl

// File: tb/tb_led_counter_ctrl.sv
// Scoreboard bench for led_counter_ctrl: directed stimulus queues expectations,
// a monitor process compares them against the outputs after each clock edge.
module tb_led_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [7:0] prescale;
    logic [3:0] led;
    logic       tick;
    logic       busy;
    logic       wrap_obs;
    logic       wrap_en;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  led;
        logic        tick;
        logic        busy;
        logic        wrap;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cycle_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

`ifdef LED_CTRL_WRAP_EN
    logic wrap;
    assign wrap_obs = wrap;
    assign wrap_en  = 1'b1;
`else
    assign wrap_obs = 1'b0;
    assign wrap_en  = 1'b0;
`endif

    led_counter_ctrl #(
        .WIDTH(4),
        .PW   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .dir     (dir),
        .load    (load),
        .load_val(load_val),
        .prescale(prescale),
`ifdef LED_CTRL_WRAP_EN
        .wrap    (wrap),
`endif
        .led     (led),
        .tick    (tick),
        .busy    (busy)
    );

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic apply(input logic r, input logic st, input logic sp, input logic d,
                         input logic ld, input logic [3:0] lv, input logic [7:0] ps,
                         input logic [3:0] el, input logic et, input logic eb,
                         input logic ew, input string nm);
        exp_t e;
        @(negedge clk);
        rst      = r;
        start    = st;
        stop     = sp;
        dir      = d;
        load     = ld;
        load_val = lv;
        prescale = ps;
        e.cyc  = cycle_cnt + 1;
        e.led  = el;
        e.tick = et;
        e.busy = eb;
        e.wrap = ew;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: compare the oldest due expectation on each falling edge.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].cyc <= cycle_cnt) begin
                m = sb_q.pop_front();
                checks++;
                if (m.cyc != cycle_cnt ||
                    {led, tick, busy, wrap_obs & wrap_en} !==
                    {m.led, m.tick, m.busy, m.wrap & wrap_en}) begin
                    errors++;
                    $display("FAIL %s cyc=%0d/%0d got led=%h tick=%b busy=%b wrap=%b want led=%h tick=%b busy=%b wrap=%b",
                             m.name, cycle_cnt, m.cyc, led, tick, busy, wrap_obs & wrap_en,
                             m.led, m.tick, m.busy, m.wrap & wrap_en);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
        load = 1'b0; load_val = 4'h0; prescale = 8'd0;

        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0, "reset");

        // Free count, prescale 0, up
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1, 1'b0, "run_enter");
        for (int k = 1; k <= 63; k++)
            apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 4'(k % 16), 1'b1, 1'b1,
                  (k % 16 == 0), "free");
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 4'hF, 1'b0, 1'b1, 1'b0, "stop_hold");
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 4'hF, 1'b0, 1'b0, 1'b0, "stop_idle");
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0, "reset2");

        // Prescale 3: a step every 4 edges
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd3, 4'h0, 1'b0, 1'b1, 1'b0, "ps_enter");
        for (int k = 1; k <= 16; k++)
            apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd3, 4'(k / 4), (k % 4 == 0), 1'b1,
                  1'b0, "ps3");
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd3, 4'h4, 1'b0, 1'b1, 1'b0, "ps_hold");
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd3, 4'h4, 1'b0, 1'b0, 1'b0, "ps_idle");

        // Load then count down through the 0 boundary
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 8'd0, 4'h2, 1'b0, 1'b0, 1'b0, "load_idle");
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 4'h2, 1'b0, 1'b1, 1'b0, "dn_enter");
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 4'h1, 1'b1, 1'b1, 1'b0, "dn1");
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 4'h0, 1'b1, 1'b1, 1'b0, "dn0");
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 4'hF, 1'b1, 1'b1, 1'b1, "dn_wrap");
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'd0, 4'hF, 1'b0, 1'b1, 1'b0, "dn_hold");
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'd0, 4'hF, 1'b0, 1'b0, 1'b0, "dn_idle");

        // Pause/resume with prescale 4: pre_cnt retained across HOLD
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'd4, 4'h0, 1'b0, 1'b0, 1'b0, "load0");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0, "pr_enter");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0, "pr_c1");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0, "pr_c2");
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0, "pr_hold");
        for (int k = 0; k < 10; k++)
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0, "pr_frozen");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0, "pr_resume");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0, "pr_r1");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd4, 4'h0, 1'b0, 1'b1, 1'b0, "pr_r2");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd4, 4'h1, 1'b1, 1'b1, 1'b0, "pr_step");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd4, 4'h1, 1'b0, 1'b1, 1'b0, "pr_after");

        // Load coincident with a step (prescale dropped to 0), then priorities
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA, 8'd0, 4'hA, 1'b0, 1'b1, 1'b0, "load_step");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 4'hB, 1'b1, 1'b1, 1'b0, "post_load");
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 4'hB, 1'b0, 1'b1, 1'b0, "pri_hold");
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 4'hB, 1'b0, 1'b0, 1'b0, "pri_idle");
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 4'hB, 1'b0, 1'b0, 1'b0, "ss_idle1");
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 4'hB, 1'b0, 1'b0, 1'b0, "ss_idle2");

        // Reset mid-run with start held
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 8'd7, 4'h9, 1'b0, 1'b0, 1'b0, "load9");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd7, 4'h9, 1'b0, 1'b1, 1'b0, "run9");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd7, 4'h9, 1'b0, 1'b1, 1'b0, "run9b");
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0, "rst_mid");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 4'h0, 1'b0, 1'b1, 1'b0, "rst_idle");
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 4'h1, 1'b1, 1'b1, 1'b0, "rst_run");

        // Bounded drain of outstanding expectations
        for (int k = 0; k < 10; k++) begin
            if (sb_q.size() != 0) @(negedge clk);
        end
        @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_led_counter_ctrl
